osc_snapshot_sync: RTL and testbench
====================================

# osc_snapshot_sync

Downstream consumer of the free-running ring-oscillator counter. It runs entirely in the `osc_clk` domain and captures the counter value on request. It hands that snapshot to an asynchronous requester, typically the AXI4-Lite register block, using a four-phase REQ/ACK handshake. Optionally it also reports the count elapsed between consecutive snapshots, which software uses to estimate oscillator frequency and entropy rate.

## Interface
Parameters:
- `COUNTER_LENGTH`, 128, width of `COUNT`, `SNAP` and `DELTA`.
- `SYNC_STAGES`, 2, flops in the REQ synchronizer; legal values are 2 or more.

Ports:
- `osc_clk`  in  1  oscillator clock; all logic in this block is clocked by it.
- `RESET`  in  1  synchronous, active-high; clock `osc_clk`.
- `COUNT`  in  `COUNTER_LENGTH`  registered counter value from the oscillator counter, same clock domain.
- `REQ`  in  1  asynchronous level request from the bus domain.
- `ACK`  out  1  registered level acknowledge.
- `SNAP`  out  `COUNTER_LENGTH`  captured count; stable whenever `ACK`=1.
- `SNAP_SEQ`  out  8  number of captures since reset, modulo 256.
- `BUSY`  out  1  high while the FSM is in HOLD.
- `DELTA`  out  `COUNTER_LENGTH`  present only with `OSC_SNAP_DELTA_EN` (see Configuration).

## Operation
- The REQ synchronizer is a `SYNC_STAGES`-flop chain; every flop resets to 0. `req_s` is the output of the last flop.
- The FSM has two states: IDLE (reset state) and HOLD.
- IDLE, with `req_s`=1, on one edge:
  - `SNAP` <= `COUNT`
  - `SNAP_SEQ` <= `SNAP_SEQ`+1 (wraps 255 -> 0)
  - `ACK` <= 1, `BUSY` <= 1
  - state <= HOLD
- IDLE, with `req_s`=0: hold all registers.
- HOLD, with `req_s`=0, on one edge:
  - `ACK` <= 0, `BUSY` <= 0
  - state <= IDLE
  - `SNAP` is unchanged.
- HOLD, with `req_s`=1: hold all registers. `SNAP` never changes in HOLD, whatever `COUNT` does.
- A new capture needs a full 0 -> 1 cycle of `req_s`. Keeping REQ high never produces a second capture.
- Reset values: `ACK`=0, `BUSY`=0, `SNAP`=0, `SNAP_SEQ`=0, `DELTA`=0, state IDLE, synchronizer 0.
- Reset during HOLD:
  - `ACK` drops to 0 on the reset edge.
  - If REQ is still high after reset is released, it is re-synchronized and a fresh capture occurs with `SNAP_SEQ`=1.
  - The requester must tolerate `ACK` falling without REQ having been released; the bus side treats this as an aborted read.
- RESET has priority over every other event on the same edge.

## Timing
- Let e0 be the first `osc_clk` edge at which REQ=1 meets setup at synchronizer stage 1.
- `req_s` goes high after edge e0+`SYNC_STAGES`-1.
- Capture happens at edge e0+`SYNC_STAGES`. `SNAP` takes the `COUNT` value present just before that edge, and `ACK` is high after it. Latency is `SYNC_STAGES`+1 edges counting e0.
- REQ falling follows the same path: `ACK` goes low `SYNC_STAGES`+1 edges after the first edge that samples REQ=0.
- The minimum full handshake is 2·(`SYNC_STAGES`+1) `osc_clk` edges plus the requester's synchronizer latency.
- REQ shorter than one `osc_clk` period may be missed. The protocol forbids this: REQ must stay high until `ACK`=1 is observed.

## Configuration
- Macro `OSC_SNAP_DELTA_EN`.
- Defined:
  - The `DELTA` port and its register exist.
  - At each capture, `DELTA` <= `COUNT` − old `SNAP`, modulo 2^`COUNTER_LENGTH`, so counter wrap-around yields the correct small difference.
  - The first capture after reset gives `DELTA` = `COUNT`.
  - `DELTA` updates on the same edge as `SNAP` and is stable while `ACK`=1.
- Undefined: no `DELTA` port and no subtractor; all other behaviour is identical.

## Test plan
- **Reset:** hold RESET 3 edges with REQ=1 and `COUNT`=0x55 -> `ACK`=0, `BUSY`=0, `SNAP`=0, `SNAP_SEQ`=0, `DELTA`=0. After release, `ACK` rises `SYNC_STAGES`+1 edges later.
- **Single capture:** drive `COUNT` equal to the edge index; raise REQ so that e0 = edge 10 -> `ACK`=1 after edge 12, `SNAP`=11, `SNAP_SEQ`=1, `BUSY`=1. `SNAP` stays 11 while `COUNT` keeps advancing.
- **Release:** drop REQ so that edge 30 first samples 0 -> `ACK`=0 after edge 32, `SNAP` still 11. Holding REQ high for 100 edges instead -> no second capture.
- **Delta and wrap (macro on):** captures at `COUNT`=100 then 350 -> `DELTA`=250. Captures at `COUNT`=2^128−10 then 5 -> `DELTA`=15.
- **Reset mid-HOLD:** assert RESET for 1 edge while `ACK`=1 and REQ=1 -> `ACK`=0 on the next edge, `SNAP_SEQ`=0. Then `ACK`=1 again `SYNC_STAGES`+1 edges after release, with `SNAP_SEQ`=1.
- **Sequence wrap:** 256 complete handshakes -> `SNAP_SEQ` reads 255 after the 255th and 0 after the 256th.

Source files
------------

// File: rtl/osc_snapshot_sync_if.sv
// Snapshot handshake bundle between osc_snapshot_sync (slave) and its requester (master).
// The DELTA signal exists only when OSC_SNAP_DELTA_EN is defined.
interface osc_snapshot_sync_if #(
   parameter int COUNTER_LENGTH = 128
);
   logic                      REQ;
   logic                      ACK;
   logic                      BUSY;
   logic [COUNTER_LENGTH-1:0] SNAP;
   logic [7:0]                SNAP_SEQ;
`ifdef OSC_SNAP_DELTA_EN
   logic [COUNTER_LENGTH-1:0] DELTA;

   modport master (output REQ, input ACK, input BUSY, input SNAP, input SNAP_SEQ, input DELTA);
   modport slave  (input REQ, output ACK, output BUSY, output SNAP, output SNAP_SEQ, output DELTA);
`else
   modport master (output REQ, input ACK, input BUSY, input SNAP, input SNAP_SEQ);
   modport slave  (input REQ, output ACK, output BUSY, output SNAP, output SNAP_SEQ);
`endif
endinterface

// File: rtl/osc_snapshot_sync.sv
// Captures the oscillator counter on a synchronized four-phase REQ/ACK handshake.
// Optional macro OSC_SNAP_DELTA_EN adds DELTA = COUNT minus the previous snapshot.
module osc_snapshot_sync #(
   parameter int COUNTER_LENGTH = 128,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                      osc_clk,
   input  logic                      RESET,
   input  logic [COUNTER_LENGTH-1:0] COUNT,
   osc_snapshot_sync_if.slave        bus
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t                    state_reg;
   state_t                    state_next;
   logic [SYNC_STAGES-1:0]    sync_reg;
   logic                      req_s;
   logic                      ack_reg;
   logic                      ack_next;
   logic                      busy_reg;
   logic                      busy_next;
   logic [COUNTER_LENGTH-1:0] snap_reg;
   logic [COUNTER_LENGTH-1:0] snap_next;
   logic [7:0]                seq_reg;
   logic [7:0]                seq_next;

   // REQ arrives from another clock domain; only req_s may be used by the FSM.
   always_ff @(posedge osc_clk) begin
      if (RESET) begin
         sync_reg[0] <= 1'b0;
      end else begin
         sync_reg[0] <= bus.REQ;
      end
   end

   genvar gi;
   generate
      for (gi = 1; gi < SYNC_STAGES; gi = gi + 1) begin : g_sync
         always_ff @(posedge osc_clk) begin
            if (RESET) begin
               sync_reg[gi] <= 1'b0;
            end else begin
               sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   assign req_s = sync_reg[SYNC_STAGES-1];

`ifdef OSC_SNAP_DELTA_EN
   logic [COUNTER_LENGTH-1:0] delta_reg;
   logic [COUNTER_LENGTH-1:0] delta_next;
`endif

   always_ff @(posedge osc_clk) begin
      if (RESET) begin
         state_reg <= IDLE;
         ack_reg   <= 1'b0;
         busy_reg  <= 1'b0;
         snap_reg  <= '0;
         seq_reg   <= 8'd0;
`ifdef OSC_SNAP_DELTA_EN
         delta_reg <= '0;
`endif
      end else begin
         state_reg <= state_next;
         ack_reg   <= ack_next;
         busy_reg  <= busy_next;
         snap_reg  <= snap_next;
         seq_reg   <= seq_next;
`ifdef OSC_SNAP_DELTA_EN
         delta_reg <= delta_next;
`endif
      end
   end

   // A capture needs a rising req_s seen from IDLE; HOLD freezes every output register.
   always_comb begin
      state_next = state_reg;
      ack_next   = ack_reg;
      busy_next  = busy_reg;
      snap_next  = snap_reg;
      seq_next   = seq_reg;
`ifdef OSC_SNAP_DELTA_EN
      delta_next = delta_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (req_s) begin
               snap_next  = COUNT;
               seq_next   = seq_reg + 8'd1;
               ack_next   = 1'b1;
               busy_next  = 1'b1;
               state_next = HOLD;
`ifdef OSC_SNAP_DELTA_EN
               delta_next = COUNT - snap_reg;
`endif
            end
         end
         HOLD: begin
            if (!req_s) begin
               ack_next   = 1'b0;
               busy_next  = 1'b0;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.ACK      = ack_reg;
   assign bus.BUSY     = busy_reg;
   assign bus.SNAP     = snap_reg;
   assign bus.SNAP_SEQ = seq_reg;
`ifdef OSC_SNAP_DELTA_EN
   assign bus.DELTA    = delta_reg;
`endif

endmodule

// File: tb/tb_osc_snapshot_sync.sv
// Scoreboard bench for osc_snapshot_sync: expectations queued at REQ, checked at ACK.
module tb_osc_snapshot_sync;
   localparam int CL = 128;
   localparam int SS = 2;

   typedef struct {
      logic [CL-1:0] snap;
      logic [7:0]    seq;
      logic [CL-1:0] delta;
   } exp_t;

   logic          osc_clk = 1'b0;
   logic          RESET   = 1'b1;
   logic [CL-1:0] count   = '0;

   exp_t          sb[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            edge_idx = 0;
   bit            follow = 1'b0;
   logic [CL-1:0] model_snap = '0;
   logic [7:0]    model_seq = 8'd0;

   osc_snapshot_sync_if #(.COUNTER_LENGTH(CL)) bus ();

   osc_snapshot_sync #(
      .COUNTER_LENGTH(CL),
      .SYNC_STAGES   (SS)
   ) dut (
      .osc_clk(osc_clk),
      .RESET  (RESET),
      .COUNT  (count),
      .bus    (bus)
   );

   always #5 osc_clk = ~osc_clk;

   task automatic tick;
      @(posedge osc_clk);
      #1;
      edge_idx++;
      if (follow) count = CL'(edge_idx);
   endtask

   task automatic push_exp(input logic [CL-1:0] c);
      exp_t e;
      e.snap  = c;
      e.seq   = model_seq + 8'd1;
      e.delta = c - model_snap;
      model_seq  = model_seq + 8'd1;
      model_snap = c;
      sb.push_back(e);
   endtask

   task automatic wait_ack(input logic lvl, output int n);
      n = 0;
      while (bus.ACK !== lvl && n < 50) begin
         tick;
         n++;
      end
      if (bus.ACK !== lvl) n = -1;
   endtask

   task automatic do_reset;
      RESET   = 1'b1;
      bus.REQ = 1'b0;
      follow  = 1'b0;
      tick;
      RESET      = 1'b0;
      model_seq  = 8'd0;
      model_snap = '0;
   endtask

   task automatic hs(input logic [CL-1:0] c, output int n_up, output logic [CL-1:0] o_snap,
                     output logic [7:0] o_seq, output logic [CL-1:0] o_delta, output int n_dn);
      count = c;
      push_exp(c);
      bus.REQ = 1'b1;
      wait_ack(1'b1, n_up);
      o_snap = bus.SNAP;
      o_seq  = bus.SNAP_SEQ;
`ifdef OSC_SNAP_DELTA_EN
      o_delta = bus.DELTA;
`else
      o_delta = '0;
`endif
      $display("hs: count=%0h snap=%0h seq=%0d up=%0d", c, o_snap, o_seq, n_up);
      bus.REQ = 1'b0;
      wait_ack(1'b0, n_dn);
   endtask

   task automatic test_reset;
      exp_t e;
      RESET = 1'b1; bus.REQ = 1'b1; count = CL'(32'h55);
      repeat (3) tick;
      n_cmp++; if (bus.ACK !== 1'b0)       begin n_bad++; $display("FAIL reset_ack: got %0b want 0", bus.ACK); end
      n_cmp++; if (bus.BUSY !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %0b want 0", bus.BUSY); end
      n_cmp++; if (bus.SNAP !== '0)        begin n_bad++; $display("FAIL reset_snap: got %0h want 0", bus.SNAP); end
      n_cmp++; if (bus.SNAP_SEQ !== 8'd0)  begin n_bad++; $display("FAIL reset_seq: got %0d want 0", bus.SNAP_SEQ); end
`ifdef OSC_SNAP_DELTA_EN
      n_cmp++; if (bus.DELTA !== '0)       begin n_bad++; $display("FAIL reset_delta: got %0h want 0", bus.DELTA); end
`endif
      model_seq = 8'd0; model_snap = '0;
      push_exp(CL'(32'h55));
      RESET = 1'b0;
      tick; tick;
      n_cmp++; if (bus.ACK !== 1'b0) begin n_bad++; $display("FAIL rel_ack_early: got %0b want 0", bus.ACK); end
      tick;
      n_cmp++; if (bus.ACK !== 1'b1) begin n_bad++; $display("FAIL rel_ack_latency: got %0b want 1", bus.ACK); end
      e = sb.pop_front();
      $display("reset release: snap=%0h seq=%0d", bus.SNAP, bus.SNAP_SEQ);
      n_cmp++; if (bus.SNAP !== e.snap)    begin n_bad++; $display("FAIL rel_snap: got %0h want %0h", bus.SNAP, e.snap); end
      n_cmp++; if (bus.SNAP_SEQ !== e.seq) begin n_bad++; $display("FAIL rel_seq: got %0d want %0d", bus.SNAP_SEQ, e.seq); end
      bus.REQ = 1'b0;
      tick;
   endtask

   task automatic test_single_capture;
      exp_t e;
      do_reset;
      edge_idx = 0; count = '0; follow = 1'b1;
      while (edge_idx < 9) tick;
      bus.REQ = 1'b1;
      push_exp(CL'(11));
      tick; tick;
      n_cmp++; if (bus.ACK !== 1'b0) begin n_bad++; $display("FAIL single_ack_e11: got %0b want 0", bus.ACK); end
      tick;
      e = sb.pop_front();
      $display("single: edge=%0d snap=%0h seq=%0d", edge_idx, bus.SNAP, bus.SNAP_SEQ);
      n_cmp++; if (bus.ACK !== 1'b1)       begin n_bad++; $display("FAIL single_ack_e12: got %0b want 1", bus.ACK); end
      n_cmp++; if (bus.BUSY !== 1'b1)      begin n_bad++; $display("FAIL single_busy: got %0b want 1", bus.BUSY); end
      n_cmp++; if (bus.SNAP !== e.snap)    begin n_bad++; $display("FAIL single_snap: got %0h want %0h", bus.SNAP, e.snap); end
      n_cmp++; if (bus.SNAP_SEQ !== e.seq) begin n_bad++; $display("FAIL single_seq: got %0d want %0d", bus.SNAP_SEQ, e.seq); end
`ifdef OSC_SNAP_DELTA_EN
      n_cmp++; if (bus.DELTA !== e.delta)  begin n_bad++; $display("FAIL single_delta: got %0h want %0h", bus.DELTA, e.delta); end
`endif
      while (edge_idx < 20) tick;
      n_cmp++; if (bus.SNAP !== CL'(11)) begin n_bad++; $display("FAIL single_snap_stable: got %0h want b", bus.SNAP); end
      while (edge_idx < 29) tick;
      bus.REQ = 1'b0;
      tick; tick;
      n_cmp++; if (bus.ACK !== 1'b1) begin n_bad++; $display("FAIL release_ack_e31: got %0b want 1", bus.ACK); end
      tick;
      n_cmp++; if (bus.ACK !== 1'b0)     begin n_bad++; $display("FAIL release_ack_e32: got %0b want 0", bus.ACK); end
      n_cmp++; if (bus.BUSY !== 1'b0)    begin n_bad++; $display("FAIL release_busy: got %0b want 0", bus.BUSY); end
      n_cmp++; if (bus.SNAP !== CL'(11)) begin n_bad++; $display("FAIL release_snap: got %0h want b", bus.SNAP); end
      follow = 1'b0;
   endtask

   task automatic test_hold_high;
      exp_t e;
      int   n;
      count = CL'(777);
      push_exp(count);
      bus.REQ = 1'b1;
      wait_ack(1'b1, n);
      n_cmp++; if (n !== SS + 1) begin n_bad++; $display("FAIL hold_up_latency: got %0d want %0d", n, SS + 1); end
      e = sb.pop_front();
      $display("hold: snap=%0h seq=%0d", bus.SNAP, bus.SNAP_SEQ);
      n_cmp++; if (bus.SNAP_SEQ !== e.seq) begin n_bad++; $display("FAIL hold_seq: got %0d want %0d", bus.SNAP_SEQ, e.seq); end
      repeat (100) begin
         count = count + CL'(1);
         tick;
      end
      n_cmp++; if (bus.ACK !== 1'b1)           begin n_bad++; $display("FAIL hold_ack: got %0b want 1", bus.ACK); end
      n_cmp++; if (bus.SNAP_SEQ !== model_seq) begin n_bad++; $display("FAIL hold_no_recapture_seq: got %0d want %0d", bus.SNAP_SEQ, model_seq); end
      n_cmp++; if (bus.SNAP !== e.snap)        begin n_bad++; $display("FAIL hold_snap: got %0h want %0h", bus.SNAP, e.snap); end
      bus.REQ = 1'b0;
      wait_ack(1'b0, n);
      n_cmp++; if (n !== SS + 1) begin n_bad++; $display("FAIL hold_down_latency: got %0d want %0d", n, SS + 1); end
   endtask

`ifdef OSC_SNAP_DELTA_EN
   task automatic test_delta;
      logic [CL-1:0] vals[4];
      logic [CL-1:0] o_snap, o_delta, big;
      logic [7:0]    o_seq;
      int            n_up, n_dn;
      exp_t          e;
      big = '1;
      big = big - CL'(9);
      vals[0] = CL'(100); vals[1] = CL'(350); vals[2] = big; vals[3] = CL'(5);
      do_reset;
      for (int i = 0; i < 4; i++) begin
         hs(vals[i], n_up, o_snap, o_seq, o_delta, n_dn);
         e = sb.pop_front();
         n_cmp++; if (o_delta !== e.delta) begin n_bad++; $display("FAIL delta_%0d: got %0h want %0h", i, o_delta, e.delta); end
         n_cmp++; if (o_snap !== e.snap)   begin n_bad++; $display("FAIL delta_snap_%0d: got %0h want %0h", i, o_snap, e.snap); end
         if (i == 1) begin
            n_cmp++; if (o_delta !== CL'(250)) begin n_bad++; $display("FAIL delta_250: got %0h want fa", o_delta); end
         end
         if (i == 3) begin
            n_cmp++; if (o_delta !== CL'(15)) begin n_bad++; $display("FAIL delta_wrap: got %0h want f", o_delta); end
         end
      end
   endtask
`endif

   task automatic test_reset_mid_hold;
      exp_t e;
      int   n;
      count = CL'(4242);
      push_exp(count);
      bus.REQ = 1'b1;
      wait_ack(1'b1, n);
      e = sb.pop_front();
      $display("pre-reset: snap=%0h seq=%0d", bus.SNAP, bus.SNAP_SEQ);
      n_cmp++; if (bus.SNAP_SEQ !== e.seq) begin n_bad++; $display("FAIL midrst_pre_seq: got %0d want %0d", bus.SNAP_SEQ, e.seq); end
      RESET = 1'b1;
      tick;
      RESET = 1'b0;
      model_seq = 8'd0; model_snap = '0;
      n_cmp++; if (bus.ACK !== 1'b0)      begin n_bad++; $display("FAIL midrst_ack: got %0b want 0", bus.ACK); end
      n_cmp++; if (bus.SNAP_SEQ !== 8'd0) begin n_bad++; $display("FAIL midrst_seq: got %0d want 0", bus.SNAP_SEQ); end
      n_cmp++; if (bus.SNAP !== '0)       begin n_bad++; $display("FAIL midrst_snap: got %0h want 0", bus.SNAP); end
      push_exp(count);
      tick; tick;
      n_cmp++; if (bus.ACK !== 1'b0) begin n_bad++; $display("FAIL midrst_early: got %0b want 0", bus.ACK); end
      tick;
      n_cmp++; if (bus.ACK !== 1'b1) begin n_bad++; $display("FAIL midrst_recapture: got %0b want 1", bus.ACK); end
      e = sb.pop_front();
      $display("post-reset: snap=%0h seq=%0d", bus.SNAP, bus.SNAP_SEQ);
      n_cmp++; if (bus.SNAP_SEQ !== e.seq) begin n_bad++; $display("FAIL midrst_post_seq: got %0d want %0d", bus.SNAP_SEQ, e.seq); end
      n_cmp++; if (bus.SNAP !== e.snap)    begin n_bad++; $display("FAIL midrst_post_snap: got %0h want %0h", bus.SNAP, e.snap); end
      bus.REQ = 1'b0;
      wait_ack(1'b0, n);
      n_cmp++; if (n < 0) begin n_bad++; $display("FAIL midrst_release_timeout: got %0d want >=0", n); end
   endtask

   task automatic test_seq_wrap;
      logic [CL-1:0] o_snap, o_delta;
      logic [7:0]    o_seq;
      int            n_up, n_dn;
      exp_t          e;
      do_reset;
      for (int i = 1; i <= 256; i++) begin
         hs(CL'(i * 3), n_up, o_snap, o_seq, o_delta, n_dn);
         e = sb.pop_front();
         n_cmp++; if (o_seq !== e.seq)   begin n_bad++; $display("FAIL wrap_seq_%0d: got %0d want %0d", i, o_seq, e.seq); end
         n_cmp++; if (o_snap !== e.snap) begin n_bad++; $display("FAIL wrap_snap_%0d: got %0h want %0h", i, o_snap, e.snap); end
         n_cmp++; if (n_up !== SS + 1 || n_dn !== SS + 1) begin
            n_bad++; $display("FAIL wrap_latency_%0d: got %0d/%0d want %0d", i, n_up, n_dn, SS + 1);
         end
         if (i == 255) begin
            n_cmp++; if (o_seq !== 8'd255) begin n_bad++; $display("FAIL wrap_seq_255: got %0d want 255", o_seq); end
         end
         if (i == 256) begin
            n_cmp++; if (o_seq !== 8'd0) begin n_bad++; $display("FAIL wrap_seq_256: got %0d want 0", o_seq); end
         end
      end
   endtask

   initial begin
      bus.REQ = 1'b0;
      test_reset;
      test_single_capture;
      test_hold_high;
`ifdef OSC_SNAP_DELTA_EN
      test_delta;
`endif
      test_reset_mid_hold;
      test_seq_wrap;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
